// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter and its benches.
package mult_pkg;

    // Default signed operand width; the product is twice this wide.
    localparam int DEFAULT_W = 12;

    // Arbiter FSM states with fixed encodings so benches can decode them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mult.sv
// Combinational radix-2 Booth multiplier: signed W x W -> exact 2*W product.
module booth_mult
    import mult_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic signed [W-1:0]   x,
    input  logic signed [W-1:0]   y,
    output logic signed [2*W-1:0] p
);

    // Multiplicand and its negation at full product width.
    // Working at 2*W keeps -(-2^(W-1)) representable.
    logic [2*W-1:0] x_ext;
    logic [2*W-1:0] x_neg;
    // Multiplier with the implicit y[-1] = 0 appended below bit 0.
    logic [W:0]     y_pad;
    logic [2*W-1:0] pp [W];
    logic [2*W-1:0] acc;

    assign x_ext = {{W{x[W-1]}}, x};
    assign x_neg = (~x_ext) + 1'b1;
    assign y_pad = {y, 1'b0};

    // One partial product per multiplier bit.
    // The bit pair (y[i], y[i-1]) selects +x, -x or 0 at weight 2^i.
    // The top pair carries the sign of y, so no correction term is needed.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_pp
            assign pp[gi] = (y_pad[gi+1:gi] == 2'b01) ? (x_ext << gi) :
                            (y_pad[gi+1:gi] == 2'b10) ? (x_neg << gi) :
                            '0;
        end
    endgenerate

    // Sum the partial products modulo 2^(2W); the result is the signed product.
    always_comb begin
        acc = '0;
        for (int i = 0; i < W; i++) begin
            acc = acc + pp[i];
        end
    end

    assign p = acc;

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared Booth multiplier.
// Each request runs IDLE -> CALC -> DONE, with the result held until it is consumed.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_p,
    output logic           res_id,
    output logic           busy
);

    state_t         state_reg;
    state_t         state_next;
    logic           rr_reg;
    logic [W-1:0]   x_reg;
    logic [W-1:0]   y_reg;
    logic           id_reg;
    logic [2*W-1:0] res_p_reg;
    logic           res_id_reg;
    logic [2*W-1:0] product;
    logic           grant_any;
    logic           grant_id;
    logic           handshake;

    // Grant a lone valid requester; on contention, rr names the winner.
    assign grant_any = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? rr_reg : req1_valid;

    // Next state and handshake outputs.
    // Ready is only offered in IDLE, so a granted valid is a handshake.
    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    handshake  = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture, round-robin pointer and result registers.
    // Operands are sampled only on the handshake edge; the product is
    // sampled only at the end of CALC, so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg     <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            id_reg     <= 1'b0;
            res_p_reg  <= '0;
            res_id_reg <= 1'b0;
        end else begin
            if (handshake) begin
                x_reg  <= grant_id ? req1_x : req0_x;
                y_reg  <= grant_id ? req1_y : req0_y;
                id_reg <= grant_id;
                rr_reg <= ~grant_id;
            end
            if (state_reg == CALC) begin
                res_p_reg  <= product;
                res_id_reg <= id_reg;
            end
        end
    end

    booth_mult #(
        .W (W)
    ) u_booth_mult (
        .x (x_reg),
        .y (y_reg),
        .p (product)
    );

    assign res_p  = res_p_reg;
    assign res_id = res_id_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter W, default 12, operand width in bits; product width is 2*W.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 presents operands.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 req0_x, req0_y  input  W each  requester 0 signed two's-complement operands.
REQ-007 req1_valid, req1_ready, req1_x, req1_y  same as REQ-004..006, for requester 1.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 res_p  output  2*W  signed product.
REQ-011 res_id  output  1  requester that owns res_p (0 or 1).
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, CALC, DONE.
REQ-014 IDLE: reqK_ready = 1 only for the granted requester K; all other ready outputs are 0.
REQ-015 Grant in IDLE: only one valid -> grant it; both valid -> grant the requester named by priority pointer rr; neither -> no grant, stay IDLE.
REQ-016 Handshake: reqK_valid & reqK_ready on a clk edge latches x, y and id = K, then IDLE -> CALC.
REQ-017 rr is set to the non-granted requester at each handshake (round-robin); rr is unchanged when no handshake occurs.
REQ-018 CALC lasts exactly one cycle: the latched operands drive booth_mult, the product is registered into res_p, then CALC -> DONE.
REQ-019 DONE: res_valid = 1; res_p and res_id stay stable until res_valid & res_ready on a clk edge; then DONE -> IDLE.
REQ-020 res_valid is 0 in IDLE and CALC; reqK_ready is 0 in CALC and DONE.
REQ-021 Latency: result visible 2 edges after the request handshake; minimum issue interval is 3 cycles per request.
REQ-022 Arithmetic: full signed W x W -> 2*W product with no truncation or saturation; -2^(W-1) x -2^(W-1) = 2^(2W-2) must be exact.
REQ-023 A requester may drop valid before it is granted; no grant and no state change results.
REQ-024 Operand inputs are sampled only on the handshake edge; later changes have no effect on the result in flight.

Reset
REQ-025 rst_n low asynchronously forces: state = IDLE, rr = 0, res_valid = 0, res_p = 0, res_id = 0, busy = 0, latched operands = 0.
REQ-026 Reset asserted during CALC or DONE discards the operation in flight; no result is ever presented for it.
REQ-027 After rst_n deasserts, the first simultaneous request is granted to requester 0.

Structure
REQ-028 The FSM state encoding (IDLE = 0, CALC = 1, DONE = 2) and the default operand width 12 are defined in a shared package (mult_pkg) for reuse by the benches.
REQ-029 Exactly one instance of the existing combinational booth_mult sub-module (ports x, y, p) is used; the arbiter adds no arithmetic of its own.

Verification
REQ-030 Single request: req0 only, x = 56, y = -12, res_ready = 1 -> res_valid rises 2 edges after the handshake with res_p = 24'hFFFD60 (-672), res_id = 0.
REQ-031 Contention: after reset, both valid, req0 = (12, 56) and req1 = (56, -12) -> results arrive in order 672 (res_id = 0), then -672 (res_id = 1); rr alternates.
REQ-032 Extremes: x = -2048, y = -2048 -> res_p = 24'h400000; x = 2047, y = -2048 -> res_p = 24'hC00800.
REQ-033 Backpressure: res_ready held low 5 cycles in DONE -> res_valid, res_p and res_id stay stable; both ready outputs stay 0; exactly one transfer follows when res_ready goes high.
REQ-034 Reset mid-op: rst_n pulsed low during CALC -> all outputs return to their reset values immediately and no res_valid is seen for that request.
REQ-035 Operand change: operands changed the cycle after the handshake -> res_p reflects the operands sampled at the handshake.
